// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronises raw keys and the slow clock, debounces each key in
// slow-clock ticks, and emits one-clock press/release pulses with optional auto-repeat.
module key_conditioner #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned DEBOUNCE_TICKS = 1,
  parameter bit          REPEAT_EN      = 1'b1,
  parameter int unsigned REPEAT_DELAY   = 3,
  parameter int unsigned REPEAT_RATE    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] held,
  output logic             any_press
);

  localparam int unsigned MAX_DR = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
  localparam int unsigned MAX_T  = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int unsigned CW     = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_PRESSED,
    ST_REPEATING,
    ST_RELEASING
  } state_e;

  logic             slow_s1_q, slow_s2_q, slow_s3_q;
  logic [WIDTH-1:0] btn_s1_q, btn_s2_q;
  logic             tick;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  logic [WIDTH-1:0] fire_press, fire_rel, held_d;
  logic [WIDTH-1:0] press_q, release_q, held_q;
  logic             any_press_q;

  assign tick = slow_s2_q & ~slow_s3_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      slow_s1_q <= 1'b0;
      slow_s2_q <= 1'b0;
      slow_s3_q <= 1'b0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
    end else begin
      slow_s1_q <= slow_clk;
      slow_s2_q <= slow_s1_q;
      slow_s3_q <= slow_s2_q;
      btn_s1_q  <= buttons;
      btn_s2_q  <= btn_s1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Level changes on the synced key win over a coincident tick in every state.
  always_comb begin
    fire_press = '0;
    fire_rel   = '0;
    held_d     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (btn_s2_q[i]) begin
            state_d[i] = ST_ARMING;
            cnt_d[i]   = '0;
          end
        end
        ST_ARMING: begin
          if (!btn_s2_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == DB_LAST) begin
              state_d[i]    = ST_PRESSED;
              cnt_d[i]      = '0;
              fire_press[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        ST_PRESSED: begin
          if (!btn_s2_q[i]) begin
            state_d[i] = ST_RELEASING;
            cnt_d[i]   = '0;
          end else if (REPEAT_EN && tick) begin
            if (cnt_q[i] == DELAY_LAST) begin
              state_d[i]    = ST_REPEATING;
              cnt_d[i]      = '0;
              fire_press[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        ST_REPEATING: begin
          if (!btn_s2_q[i]) begin
            state_d[i] = ST_RELEASING;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == RATE_LAST) begin
              cnt_d[i]      = '0;
              fire_press[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        ST_RELEASING: begin
          if (btn_s2_q[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == DB_LAST) begin
              state_d[i]  = ST_IDLE;
              cnt_d[i]    = '0;
              fire_rel[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_REPEATING) ||
                  (state_d[i] == ST_RELEASING);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      press_q     <= '0;
      release_q   <= '0;
      held_q      <= '0;
      any_press_q <= 1'b0;
    end else begin
      press_q     <= fire_press;
      release_q   <= fire_rel;
      held_q      <= held_d;
      any_press_q <= |fire_press;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign held          = held_q;
  assign any_press     = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: expected pulses are queued when ticks are driven
// and popped when the DUT emits a pulse.
module tb_key_conditioner;
  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         slow_clk;
  logic [W-1:0] buttons;
  logic [W-1:0] press_pulse, release_pulse, held;
  logic         any_press;
  logic [W-1:0] press_nr, release_nr, held_nr;
  logic         any_nr;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] press;
    logic [W-1:0] rel;
  } exp_t;

  exp_t sb[$];
  exp_t sb_nr[$];

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned cyc        = 0;
  int unsigned last_rise  = 0;
  int unsigned rises      = 0;
  int unsigned phase      = 19;

  key_conditioner #(
    .WIDTH(W), .DEBOUNCE_TICKS(1), .REPEAT_EN(1'b1), .REPEAT_DELAY(3), .REPEAT_RATE(1)
  ) dut (
    .clock(clock), .reset(reset), .slow_clk(slow_clk), .buttons(buttons),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .held(held), .any_press(any_press)
  );

  key_conditioner #(
    .WIDTH(W), .DEBOUNCE_TICKS(1), .REPEAT_EN(1'b0), .REPEAT_DELAY(3), .REPEAT_RATE(1)
  ) dut_nr (
    .clock(clock), .reset(reset), .slow_clk(slow_clk), .buttons(buttons),
    .press_pulse(press_nr), .release_pulse(release_nr), .held(held_nr), .any_press(any_nr)
  );

  always #5 clock = ~clock;

  // One clock step; slow_clk has a 20-clock period, and a rise driven in step r shows as a
  // pulse at step r+3 when the tick fires.
  task automatic advance();
    @(posedge clock);
    #1;
    cyc++;
    phase    = (phase == 19) ? 0 : phase + 1;
    slow_clk = (phase < 10);
    if (phase == 0) begin
      rises++;
      last_rise = cyc;
    end
  endtask

  task automatic wait_rise();
    for (int n = 0; n < 25; n++) begin
      advance();
      if (cyc == last_rise) return;
    end
    compared++;
    mismatched++;
    $display("FAIL wait_rise: no slow_clk rise within 25 clocks (cyc %0d)", cyc);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    buttons = '1;
    for (int n = 0; n < 40; n++) begin
      advance();
      compared++;
      if ({press_pulse, release_pulse, held, any_press, press_nr, release_nr, held_nr, any_nr} !== '0) begin
        mismatched++;
        $display("FAIL reset_hold: cyc %0d press=%b rel=%b held=%b any=%b, required all 0",
                 cyc, press_pulse, release_pulse, held, any_press);
      end
    end
    buttons = '0;
    reset   = 1'b0;
    advance();
    compared++;
    if ({press_pulse, release_pulse, held, any_press, press_nr, release_nr, held_nr, any_nr} !== '0) begin
      mismatched++;
      $display("FAIL reset_release: press=%b rel=%b held=%b any=%b, required all 0",
               press_pulse, release_pulse, held, any_press);
    end
    repeat (45) advance();
  endtask

  task automatic test_clean_press();
    int unsigned base, k;
    exp_t e;
    logic exp_held;
    wait_rise();
    base       = rises;
    buttons[0] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      advance();
      k = rises - base;
      if (cyc == last_rise && k == 1) sb_nr.push_back(exp_t'{cyc + 3, 4'b0001, 4'b0000});
      if (cyc == last_rise && k == 4) sb_nr.push_back(exp_t'{cyc + 3, 4'b0000, 4'b0001});
      // held rises in the press-pulse cycle of tick 1 and falls in the release-pulse cycle of tick 4
      if ((k == 1 || k == 4) && (cyc == last_rise + 2 || cyc == last_rise + 3)) begin
        exp_held = ((k == 1) == (cyc == last_rise + 3));
        compared++;
        if (held_nr[0] !== exp_held) begin
          mismatched++;
          $display("FAIL clean_held: cyc %0d held[0]=%b required %b", cyc, held_nr[0], exp_held);
        end
      end
      if (sb_nr.size() > 0 && sb_nr[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL clean_missing: pulse due cyc %0d press=%b rel=%b never seen",
                 sb_nr[0].cyc, sb_nr[0].press, sb_nr[0].rel);
        void'(sb_nr.pop_front());
      end
      if ((press_nr | release_nr) != '0) begin
        compared++;
        if (sb_nr.size() == 0) begin
          mismatched++;
          $display("FAIL clean_unexpected: cyc %0d press=%b rel=%b, required none", cyc, press_nr, release_nr);
        end else begin
          e = sb_nr.pop_front();
          if ({cyc, press_nr, release_nr, any_nr} !== {e.cyc, e.press, e.rel, |e.press}) begin
            mismatched++;
            $display("FAIL clean_pulse: cyc %0d press=%b rel=%b any=%b, required cyc %0d press=%b rel=%b any=%b",
                     cyc, press_nr, release_nr, any_nr, e.cyc, e.press, e.rel, |e.press);
          end
        end
      end
      if (k == 3 && cyc == last_rise + 5) buttons[0] = 1'b0;
    end
    compared++;
    if (sb_nr.size() != 0) begin
      mismatched++;
      $display("FAIL clean_drain: %0d expected pulses left, required 0", sb_nr.size());
    end
  endtask

  task automatic test_bounce();
    int unsigned r0;
    exp_t e;
    wait_rise();
    r0 = cyc;
    for (int n = 0; n < 70; n++) begin
      advance();
      compared++;
      if (held[1] !== 1'b0) begin
        mismatched++;
        $display("FAIL bounce_held: cyc %0d held[1]=%b required 0", cyc, held[1]);
      end
      if ((press_pulse | release_pulse) != '0) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL bounce_unexpected: cyc %0d press=%b rel=%b, required none",
                   cyc, press_pulse, release_pulse);
        end else begin
          e = sb.pop_front();
          mismatched++;
          $display("FAIL bounce_stale: cyc %0d press=%b, stale entry cyc %0d", cyc, press_pulse, e.cyc);
        end
      end
      if (cyc >= r0 + 4 && cyc <= r0 + 19 && (cyc - r0 - 4) % 3 == 0)
        buttons[1] = (((cyc - r0 - 4) / 3) % 2 == 0);
    end
  endtask

  task automatic test_auto_repeat();
    int unsigned base, k;
    exp_t e;
    wait_rise();
    base       = rises;
    buttons[2] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      advance();
      k = rises - base;
      if (cyc == last_rise && (k == 1 || (k >= 4 && k <= 8)))
        sb.push_back(exp_t'{cyc + 3, 4'b0100, 4'b0000});
      if (cyc == last_rise && k == 9) sb.push_back(exp_t'{cyc + 3, 4'b0000, 4'b0100});
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL repeat_missing: pulse due cyc %0d press=%b rel=%b never seen",
                 sb[0].cyc, sb[0].press, sb[0].rel);
        void'(sb.pop_front());
      end
      if ((press_pulse | release_pulse) != '0) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL repeat_unexpected: cyc %0d press=%b rel=%b, required none",
                   cyc, press_pulse, release_pulse);
        end else begin
          e = sb.pop_front();
          if ({cyc, press_pulse, release_pulse, any_press} !== {e.cyc, e.press, e.rel, |e.press}) begin
            mismatched++;
            $display("FAIL repeat_pulse: cyc %0d press=%b rel=%b any=%b, required cyc %0d press=%b rel=%b any=%b",
                     cyc, press_pulse, release_pulse, any_press, e.cyc, e.press, e.rel, |e.press);
          end
        end
      end
      if (k == 8 && cyc == last_rise + 5) buttons[2] = 1'b0;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL repeat_drain: %0d expected pulses left, required 0", sb.size());
    end
  endtask

  task automatic test_simultaneous();
    int unsigned base, k;
    exp_t e;
    wait_rise();
    base    = rises;
    buttons = 4'b1001;
    for (int n = 0; n < 60; n++) begin
      advance();
      k = rises - base;
      if (cyc == last_rise && k == 1) sb.push_back(exp_t'{cyc + 3, 4'b1001, 4'b0000});
      if (cyc == last_rise && k == 2) sb.push_back(exp_t'{cyc + 3, 4'b0000, 4'b1001});
      if (k == 1 && cyc == last_rise + 3) begin
        compared++;
        if (held !== 4'b1001) begin
          mismatched++;
          $display("FAIL simul_held: held=%b required 1001", held);
        end
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL simul_missing: pulse due cyc %0d press=%b rel=%b never seen",
                 sb[0].cyc, sb[0].press, sb[0].rel);
        void'(sb.pop_front());
      end
      if ((press_pulse | release_pulse) != '0) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL simul_unexpected: cyc %0d press=%b rel=%b, required none",
                   cyc, press_pulse, release_pulse);
        end else begin
          e = sb.pop_front();
          if ({cyc, press_pulse, release_pulse, any_press} !== {e.cyc, e.press, e.rel, |e.press}) begin
            mismatched++;
            $display("FAIL simul_pulse: cyc %0d press=%b rel=%b any=%b, required cyc %0d press=%b rel=%b any=%b",
                     cyc, press_pulse, release_pulse, any_press, e.cyc, e.press, e.rel, |e.press);
          end
        end
      end
      if (k == 1 && cyc == last_rise + 5) buttons = 4'b0000;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL simul_drain: %0d expected pulses left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned base, k;
    exp_t e;
    wait_rise();
    base       = rises;
    buttons[2] = 1'b1;
    for (int n = 0; n < 160; n++) begin
      advance();
      k = rises - base;
      if (cyc == last_rise && (k == 1 || k == 4 || k == 5 || k == 6))
        sb.push_back(exp_t'{cyc + 3, 4'b0100, 4'b0000});
      if (cyc == last_rise && k == 7) sb.push_back(exp_t'{cyc + 3, 4'b0000, 4'b0100});
      if (k == 5 && cyc == last_rise + 5) begin
        compared++;
        if (held[2] !== 1'b1) begin
          mismatched++;
          $display("FAIL midreset_pre_held: held[2]=%b required 1", held[2]);
        end
      end
      if (k == 5 && cyc == last_rise + 6) begin
        compared++;
        if ({press_pulse, release_pulse, held, any_press} !== '0) begin
          mismatched++;
          $display("FAIL midreset_clear: press=%b rel=%b held=%b any=%b, required all 0",
                   press_pulse, release_pulse, held, any_press);
        end
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL midreset_missing: pulse due cyc %0d press=%b rel=%b never seen",
                 sb[0].cyc, sb[0].press, sb[0].rel);
        void'(sb.pop_front());
      end
      if ((press_pulse | release_pulse) != '0) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL midreset_unexpected: cyc %0d press=%b rel=%b, required none",
                   cyc, press_pulse, release_pulse);
        end else begin
          e = sb.pop_front();
          if ({cyc, press_pulse, release_pulse, any_press} !== {e.cyc, e.press, e.rel, |e.press}) begin
            mismatched++;
            $display("FAIL midreset_pulse: cyc %0d press=%b rel=%b any=%b, required cyc %0d press=%b rel=%b any=%b",
                     cyc, press_pulse, release_pulse, any_press, e.cyc, e.press, e.rel, |e.press);
          end
        end
      end
      if (k == 5 && cyc == last_rise + 5) reset = 1'b1;
      if (k == 5 && cyc == last_rise + 6) reset = 1'b0;
      if (k == 6 && cyc == last_rise + 5) buttons[2] = 1'b0;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL midreset_drain: %0d expected pulses left, required 0", sb.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    buttons  = '1;
    slow_clk = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
